// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between an instruction-fetch port and a load/store port.
// Data has priority, bounded by a starvation limit; a response timeout returns an error.
module mem_arbiter #(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0]  StreakMax = 8'(MAX_STREAK);
  localparam logic [15:0] TmoLast   = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;
  typedef enum logic [0:0] {OwnIf, OwnD} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [7:0]  streak_q, streak_d;
  logic [15:0] tmo_q, tmo_d;

  logic        if_rvalid_q, if_rvalid_d;
  logic        if_err_q, if_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        idle;
  logic        grant_d;
  logic        grant_if;
  logic        accept;
  logic        resp_fire;
  logic [31:0] resp_data;
  logic        resp_err;

  // Reset gates the combinational handshake so nothing is offered while reset is held.
  always_comb begin
    idle     = (state_q == StIdle) && !reset;
    grant_d  = idle && d_req && !(if_req && (streak_q == StreakMax));
    grant_if = idle && if_req && !grant_d;
    accept   = (grant_d || grant_if) && mem_ready;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant_d) begin
      mem_req   = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
    end else if (grant_if) begin
      mem_req  = 1'b1;
      mem_addr = if_addr;
    end
    if_ready = grant_if && mem_ready;
    d_ready  = grant_d && mem_ready;
  end

  // A real response in the final timeout cycle takes precedence over the error.
  always_comb begin
    resp_fire = (state_q == StWait) && (mem_rvalid || (tmo_q == TmoLast));
    resp_data = mem_rvalid ? mem_rdata : 32'h0;
    resp_err  = !mem_rvalid;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          owner_d = grant_d ? OwnD : OwnIf;
          tmo_d   = '0;
          if (grant_d && if_req) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 8'd1;
          end else begin
            streak_d = '0;
          end
        end
      end
      StWait: begin
        tmo_d = tmo_q + 16'd1;
        if (resp_fire) begin
          state_d = StIdle;
          tmo_d   = '0;
          if (owner_q == OwnD) begin
            d_rvalid_d = 1'b1;
            d_err_d    = resp_err;
            d_rdata_d  = resp_data;
          end else begin
            if_rvalid_d = 1'b1;
            if_err_d    = resp_err;
            if_rdata_d  = resp_data;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      streak_q    <= '0;
      tmo_q       <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int unsigned MaxStreak = 4;
  localparam int unsigned Timeout   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_STREAK(MaxStreak), .TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending transaction, how long it has waited, how many
  // data grants in a row fetch has watched go by, and what each requester last received.
  bit          m_busy = 1'b0;
  bit          m_owner_is_d = 1'b0;
  int          m_waited = 0;
  int          m_streak = 0;
  logic        m_if_rvalid = 1'b0, m_if_err = 1'b0, m_d_rvalid = 1'b0, m_d_err = 1'b0;
  logic [31:0] m_if_rdata = '0, m_d_rdata = '0;

  always @(negedge clk) begin
    bit          d_wins, if_wins;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_wstrb;
    if (reset) begin
      m_busy = 1'b0; m_waited = 0; m_streak = 0; m_owner_is_d = 1'b0;
      m_if_rvalid = 1'b0; m_if_err = 1'b0; m_if_rdata = '0;
      m_d_rvalid = 1'b0; m_d_err = 1'b0; m_d_rdata = '0;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_mem_addr", mem_addr, 0);
    end else begin
      d_wins  = !m_busy && d_req && !(if_req && m_streak == MaxStreak);
      if_wins = !m_busy && if_req && !d_wins;
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      if (d_wins) begin
        e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_wstrb;
      end else if (if_wins) begin
        e_addr = if_addr;
      end
      chk("m_mem_req", mem_req, 32'(!m_busy && (if_req || d_req)));
      chk("m_if_ready", if_ready, 32'(if_wins && mem_ready));
      chk("m_d_ready", d_ready, 32'(d_wins && mem_ready));
      if (!m_busy) begin
        chk("m_mem_we", mem_we, 32'(e_we));
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_wdata", mem_wdata, e_wdata);
        chk("m_mem_wstrb", mem_wstrb, 32'(e_wstrb));
      end
    end
    chk("m_if_rvalid", if_rvalid, 32'(m_if_rvalid));
    chk("m_if_err", if_err, 32'(m_if_err));
    chk("m_if_rdata", if_rdata, m_if_rdata);
    chk("m_d_rvalid", d_rvalid, 32'(m_d_rvalid));
    chk("m_d_err", d_err, 32'(m_d_err));
    chk("m_d_rdata", d_rdata, m_d_rdata);

    // Advance the model to what the coming rising edge must produce.
    if (!reset) begin
      m_if_rvalid = 1'b0; m_if_err = 1'b0; m_d_rvalid = 1'b0; m_d_err = 1'b0;
      if (!m_busy) begin
        if ((d_wins || if_wins) && mem_ready) begin
          m_busy = 1'b1;
          m_owner_is_d = d_wins;
          m_waited = 0;
          if (d_wins && if_req) m_streak = (m_streak < MaxStreak) ? m_streak + 1 : m_streak;
          else m_streak = 0;
        end
      end else begin
        m_waited++;
        if (mem_rvalid || m_waited == Timeout) begin
          m_busy = 1'b0;
          if (m_owner_is_d) begin
            m_d_rvalid = 1'b1; m_d_err = !mem_rvalid; m_d_rdata = mem_rvalid ? mem_rdata : '0;
          end else begin
            m_if_rvalid = 1'b1; m_if_err = !mem_rvalid; m_if_rdata = mem_rvalid ? mem_rdata : '0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit exp_d[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rvalid", d_rvalid, 0);

    // Single fetch, memory responds two cycles after acceptance.
    step();
    if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1;
    #2;
    chk("t1_if_ready", if_ready, 1);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_we", mem_we, 0);
    step(); if_req = 1'b0; mem_ready = 1'b0;
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h00B50533;
    step(); mem_rvalid = 1'b0;
    #2;
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'h00B50533);
    chk("t1_if_err", if_err, 0);
    chk("t1_d_rvalid", d_rvalid, 0);
    step(); #2;
    chk("t1_if_rvalid_pulse", if_rvalid, 0);
    chk("t1_if_rdata_hold", if_rdata, 32'h00B50533);

    // Simultaneous requests: store first, fetch on the next idle cycle.
    step();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    mem_ready = 1'b1;
    #2;
    chk("t2_d_ready", d_ready, 1);
    chk("t2_if_ready", if_ready, 0);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_wstrb", mem_wstrb, 32'hF);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    step(); mem_rvalid = 1'b0;
    #2;
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_if_ready", if_ready, 1);
    chk("t2_if_mem_addr", mem_addr, 32'h20);
    step(); if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13;
    step(); mem_rvalid = 1'b0;
    #2;
    chk("t2_if_rvalid", if_rvalid, 1);
    chk("t2_if_rdata", if_rdata, 32'h13);

    // Starvation limit: D,D,D,D,IF,D with both requests held.
    step();
    if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("t3_grant%0d_d", i), d_ready, 32'(exp_d[i]));
      chk($sformatf("t3_grant%0d_if", i), if_ready, 32'(!exp_d[i]));
      step(); mem_rvalid = 1'b1; mem_rdata = 32'h1000 + i;
      step(); mem_rvalid = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    #2;
    chk("t3_last_d_rdata", d_rdata, 32'h1005);
    chk("t3_if_rdata", if_rdata, 32'h1004);

    // Load with no memory response times out after 16 waiting cycles.
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ready = 1'b1;
    #2 chk("t4_d_ready", d_ready, 1);
    step(); d_req = 1'b0; mem_ready = 1'b0;
    repeat (15) step();
    #2 chk("t4_no_early_rvalid", d_rvalid, 0);
    step(); #2;
    chk("t4_d_rvalid", d_rvalid, 1);
    chk("t4_d_err", d_err, 1);
    chk("t4_d_rdata", d_rdata, 0);
    chk("t4_if_rvalid", if_rvalid, 0);
    step(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    step(); mem_rvalid = 1'b0;
    #2;
    chk("t4_stray_d_rvalid", d_rvalid, 0);
    chk("t4_stray_if_rvalid", if_rvalid, 0);
    chk("t4_stray_d_rdata", d_rdata, 0);

    // Response arriving in the final timeout cycle is delivered without error.
    step();
    d_req = 1'b1; d_addr = 32'h204; mem_ready = 1'b1;
    step(); d_req = 1'b0; mem_ready = 1'b0;
    repeat (15) step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    step(); mem_rvalid = 1'b0;
    #2;
    chk("t4b_d_rvalid", d_rvalid, 1);
    chk("t4b_d_err", d_err, 0);
    chk("t4b_d_rdata", d_rdata, 32'hCAFE);

    // Backpressure: fetch presented for 5 cycles before the memory accepts.
    step();
    if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("t5_mem_req%0d", i), mem_req, 1);
      chk($sformatf("t5_if_ready%0d", i), if_ready, 0);
      chk($sformatf("t5_mem_addr%0d", i), mem_addr, 32'h40);
      step();
    end
    mem_ready = 1'b1;
    #2 chk("t5_accept", if_ready, 1);
    step(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    step(); mem_rvalid = 1'b0;
    #2;
    chk("t5_if_rvalid", if_rvalid, 1);
    chk("t5_if_rdata", if_rdata, 32'h77);

    // Reset while a fetch is outstanding drops it.
    step();
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b1;
    step(); if_req = 1'b0; mem_ready = 1'b0;
    step();
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
    #2;
    chk("t6_mem_req", mem_req, 0);
    chk("t6_if_ready", if_ready, 0);
    chk("t6_d_ready", d_ready, 0);
    chk("t6_if_rdata", if_rdata, 0);
    chk("t6_d_rdata", d_rdata, 0);
    step();
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    step(); mem_rvalid = 1'b0;
    #2;
    chk("t6_no_if_rvalid", if_rvalid, 0);
    chk("t6_if_rdata_clear", if_rdata, 0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
